// File: rtl/risc_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : risc_mem_responder_if
// Description : Request/response bus between a RISC core and the wait-state
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface risc_mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  // Core side drives requests and observes completion.
  modport master (
    output req, we, addr, wdata,
    input  busy, ack, rdata, err
  );

  // Responder side samples requests and reports completion.
  modport slave (
    input  req, we, addr, wdata,
    output busy, ack, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/risc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : risc_mem_responder
// Description : Single-port word memory answering core requests after a
//               fixed number of wait cycles, with out-of-range detection.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_mem_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64,
  parameter int WAIT   = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  risc_mem_responder_if.slave   bus
);

  localparam int              c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]      c_wait_load = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;
  localparam bit              c_zero_wait = (WAIT == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic                w_do_access;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_acc_we;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic [c_idx_w-1:0]  w_idx;
  logic                w_in_range;
  logic                w_mem_we;

  logic                r_busy;
  logic                r_ack;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  // With zero wait states the access happens on the accepting edge, so the
  // live bus values are used in IDLE; otherwise the latched copy is used.
  assign w_acc_we    = (r_state == S_IDLE) ? bus.we    : r_we;
  assign w_acc_addr  = (r_state == S_IDLE) ? bus.addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? bus.wdata : r_wdata;
  assign w_idx       = w_acc_addr[c_idx_w-1:0];
  assign w_in_range  = ({1'b0, w_acc_addr} < c_depth);
  // Memory is written only on a clock edge seen while out of reset.
  assign w_mem_we    = w_do_access & w_acc_we & w_in_range & reset;

  // State and wait-counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; flags the edge on which the memory access happens.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_do_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (c_zero_wait) begin
            w_state_nxt = S_DONE;
            w_do_access = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_wait_load;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_DONE;
          w_do_access = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the request so later bus activity cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if ((r_state == S_IDLE) && bus.req) begin
      r_we    <= bus.we;
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
    end
  end

  // Registered outputs; out-of-range accesses return zero and raise err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_ack  <= w_do_access;
      r_err  <= w_do_access & ~w_in_range;
      if (w_do_access && !w_in_range) begin
        r_rdata <= '0;
      end else if (w_do_access && !w_acc_we) begin
        r_rdata <= r_mem[w_idx];
      end
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

  assign bus.busy  = r_busy;
  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_risc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_mem_responder
// Description : Directed self-checking bench for risc_mem_responder with a
//               WAIT=2 instance (sel 0) and a WAIT=0 instance (sel 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_mem_responder;

  logic clk;
  logic reset;

  risc_mem_responder_if #(.DATA_W(16), .ADDR_W(8)) b2 ();
  risc_mem_responder_if #(.DATA_W(16), .ADDR_W(8)) b0 ();

  risc_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(64), .WAIT(2)) u_w2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  risc_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(64), .WAIT(0)) u_w0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mem_m  [2][256];
  logic [15:0] exp_rd [2];
  int          n_checks = 0;
  int          n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit sel, input logic rq, input logic w,
                       input logic [7:0] a, input logic [15:0] d);
    if (sel) begin
      b0.req = rq; b0.we = w; b0.addr = a; b0.wdata = d;
    end else begin
      b2.req = rq; b2.we = w; b2.addr = a; b2.wdata = d;
    end
  endtask

  function automatic logic get_ack(input bit sel);
    return sel ? b0.ack : b2.ack;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? b0.busy : b2.busy;
  endfunction
  function automatic logic get_err(input bit sel);
    return sel ? b0.err : b2.err;
  endfunction
  function automatic logic [15:0] get_rdata(input bit sel);
    return sel ? b0.rdata : b2.rdata;
  endfunction

  // One request pulse; optional perturbation of the bus while busy.
  task automatic xact(input bit sel, input logic w, input logic [7:0] a,
                      input logic [15:0] d, input bit pert);
    exp_t e;
    int   lat;
    bit   got;
    e.err = (a >= 8'd64);
    if (e.err)  exp_rd[sel] = 16'h0000;
    else if (w) mem_m[sel][a] = d;
    else        exp_rd[sel] = mem_m[sel][a];
    e.rdata = exp_rd[sel];
    sb.push_back(e);
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    @(negedge clk);
    if (pert) drive(sel, 1'b0, ~w, 8'h09, 16'hDEAD);
    else      drive(sel, 1'b0, w, a, d);
    chk("busy_after_accept", get_busy(sel), 1);
    lat = 0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (get_ack(sel)) got = 1;
      else begin
        lat++;
        @(negedge clk);
      end
    end
    chk("ack_seen", got, 1);
    if (got) begin
      e = sb.pop_front();
      chk("latency", lat, sel ? 0 : 2);
      chk("rdata", get_rdata(sel), e.rdata);
      chk("err", get_err(sel), e.err);
      @(negedge clk);
      chk("ack_fall", get_ack(sel), 0);
      chk("err_low", get_err(sel), 0);
      chk("busy_idle", get_busy(sel), 0);
    end
  endtask

  // Request held high for a number of cycles; checks the accept cadence.
  task automatic held(input bit sel, input int cycles, input logic [7:0] a);
    int          w;
    logic [15:0] obs_busy, exp_busy, obs_ack, exp_ack;
    w = sel ? 0 : 2;
    obs_busy = '0; exp_busy = '0; obs_ack = '0; exp_ack = '0;
    exp_rd[sel] = mem_m[sel][a];
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, a, 16'h0000);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      obs_busy[i] = get_busy(sel);
      obs_ack[i]  = get_ack(sel);
      exp_busy[i] = ((i % (w + 2)) != (w + 1));
      exp_ack[i]  = ((i % (w + 2)) == w);
      if (get_ack(sel)) chk("held_rdata", get_rdata(sel), exp_rd[sel]);
    end
    drive(sel, 1'b0, 1'b0, a, 16'h0000);
    chk("held_busy_pattern", obs_busy, exp_busy);
    chk("held_ack_pattern", obs_ack, exp_ack);
    @(negedge clk);
    chk("held_idle_after", get_busy(sel), 0);
  endtask

  initial begin
    bit ack_seen;
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;

    // Asynchronous reset before any clock edge.
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy_w2", b2.busy, 0);
    chk("rst_ack_w2", b2.ack, 0);
    chk("rst_err_w2", b2.err, 0);
    chk("rst_rdata_w2", b2.rdata, 0);
    chk("rst_busy_w0", b0.busy, 0);
    chk("rst_ack_w0", b0.ack, 0);
    chk("rst_rdata_w0", b0.rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Setup writes and the write/read pair.
    xact(0, 1'b1, 8'h00, 16'h0F0F, 0);
    xact(0, 1'b1, 8'h05, 16'hA5A5, 0);
    xact(0, 1'b0, 8'h05, 16'h0000, 0);
    xact(0, 1'b1, 8'h03, 16'h3333, 0);
    xact(0, 1'b1, 8'h07, 16'h0001, 0);
    xact(0, 1'b1, 8'h09, 16'h1111, 0);
    xact(0, 1'b0, 8'h3F, 16'h0000, 0);
    xact(0, 1'b0, 8'h07, 16'h0000, 0);

    // Out of range, then a read of addr 0 is unaffected.
    xact(0, 1'b1, 8'h40, 16'h1234, 0);
    xact(0, 1'b0, 8'h00, 16'h0000, 0);
    xact(0, 1'b0, 8'hFF, 16'h0000, 0);

    // Held request.
    held(0, 12, 8'h00);

    // Bus changes while busy: read of 3 completes, mem[9] untouched.
    xact(0, 1'b0, 8'h03, 16'h0000, 1);
    xact(0, 1'b0, 8'h09, 16'h0000, 0);

    // Reset one cycle after accepting a write to addr 7.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h07, 16'hBEEF);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    chk("midrst_busy", b2.busy, 0);
    chk("midrst_ack", b2.ack, 0);
    chk("midrst_err", b2.err, 0);
    chk("midrst_rdata", b2.rdata, 0);
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
    ack_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (b2.ack) ack_seen = 1;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (b2.ack) ack_seen = 1;
    end
    chk("midrst_no_ack", ack_seen, 0);
    xact(0, 1'b0, 8'h07, 16'h0000, 0);

    // Zero-wait instance.
    xact(1, 1'b1, 8'h02, 16'h2222, 0);
    xact(1, 1'b0, 8'h02, 16'h0000, 0);
    xact(1, 1'b1, 8'h41, 16'h5555, 0);
    held(1, 4, 8'h02);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc_mem_responder.md
RISC_MEM_RESPONDER -- requirements
Module: risc_mem_responder

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-002 Parameter ADDR_W, default 8, SHALL set the request address width.
REQ-003 Parameter DEPTH, default 64, SHALL set the number of implemented words; DEPTH SHALL be at most 2**ADDR_W.
REQ-004 Parameter WAIT, default 2, range 0..7, SHALL set the number of wait cycles inserted before each access completes.
REQ-005 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes occur on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  the core requests an access; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; latched with req.
- addr  in  ADDR_W  word address; latched with req.
- wdata  in  DATA_W  write data; latched with req.
- busy  out  1  high whenever the state is not IDLE.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid when ack=1 and the latched we was 0.
- err  out  1  out-of-range flag; pulses with ack.

Function
REQ-006 The block SHALL implement states IDLE, WAIT and DONE, with state and all outputs registered.
REQ-007 In IDLE, req=1 at edge N SHALL latch we, addr and wdata and then transition:
- to WAIT with the wait counter loaded to WAIT-1, when WAIT>0;
- directly to DONE, performing the access at edge N, when WAIT=0.
REQ-008 In WAIT, the counter SHALL decrement each edge. The edge at which the counter equals 0 SHALL perform the access and transition to DONE.
REQ-009 Latency: with req sampled at edge N, ack SHALL rise at edge N+WAIT and fall at edge N+WAIT+1.
REQ-010 DONE SHALL last exactly one cycle and return to IDLE unconditionally. A request held continuously is therefore accepted every WAIT+2 cycles.
REQ-011 Changes on req, we, addr and wdata outside IDLE SHALL be ignored; the access SHALL use the latched values.
REQ-012 Access with latched addr < DEPTH:
- write: mem[addr] <= wdata; rdata unchanged.
- read: rdata <= mem[addr].
- err SHALL be 0 in both cases.
REQ-013 Access with latched addr >= DEPTH:
- no memory write;
- rdata <= 0;
- err SHALL pulse with ack;
- no address wrap-around or aliasing.
REQ-014 rdata SHALL hold its value until the next read access or reset. err SHALL be 0 whenever ack=0.
REQ-015 Memory contents SHALL NOT be cleared by reset and are undefined until written.

Reset
REQ-016 reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0, busy=0, ack=0, err=0 and rdata=0.
REQ-017 A reset asserted before the access edge SHALL abort the request with no memory write and no ack. A write already performed SHALL persist.
REQ-018 The first request after reset deassertion SHALL be sampled at the first rising edge where reset=1 and req=1.

Verification (WAIT=2 unless stated)
REQ-019 The bench SHALL cover the following scenarios:
- Write/read: write 0xA5A5 to addr 5, req at edge N -> ack=1 only between edges N+2 and N+3, err=0. Then read addr 5 -> rdata=0xA5A5 with ack.
- Out of range: write 0x1234 to addr 0x40 -> ack=1, err=1, rdata=0. A subsequent read of addr 0x00 returns its previously written value (0x0F0F) unchanged.
- Held req: req held high for 12 cycles -> accepts at edges N, N+4 and N+8; busy low for exactly one cycle between transactions.
- Input changes while busy: during WAIT, addr switches 3->9 and we switches 0->1 -> a read of addr 3 completes and mem[9] is unchanged.
- Reset mid-operation: reset=0 one cycle after accepting a write of 0xBEEF to addr 7 -> busy, ack, err and rdata are 0 at once, no ack follows, and mem[7] keeps its old value (0x0001).
- WAIT=0 instance: read addr 2 at edge N -> ack high between edges N and N+1; next request accepted at edge N+2.
